// File: rtl/edge_pulse_gen.sv
// Programmable edge strobe / square-wave generator. One oedge every P clocks,
// wave high for min(H, P-1) clocks of each period; new P/H only at boundaries.
module edge_pulse_gen #(
    parameter int WIDTH      = 8,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             oedge,
    output logic             wave,
    output logic             busy,
    output logic             pending,
    output logic             load_ack,
    output logic             load_err
);

    // state | meaning
    // IDLE  | stopped, k=0, pending settings applied immediately
    // RUN   | generating, k counts 1..P
    // DRAIN | enable dropped, finishing the current period
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_per;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_sh_per;
    logic [WIDTH-1:0] r_sh_high;
    logic             r_pending;
    logic             r_oedge;
    logic             r_wave;
    logic             r_busy;
    logic             r_load_ack;
    logic             r_load_err;

    logic             w_boundary;
    logic             w_apply;
    logic             w_load_ok;
    logic             w_load_bad;
    logic [WIDTH-1:0] w_k_nxt;
    logic [WIDTH-1:0] w_per_nxt;
    logic [WIDTH-1:0] w_high_nxt;
    logic [WIDTH-1:0] w_hlim;
    logic             w_pending_nxt;
    logic             w_oedge_nxt;
    logic             w_wave_nxt;
    logic             w_busy_nxt;

    assign w_boundary = (r_state != S_IDLE) && (r_k == r_per);
    assign w_apply    = r_pending && ((r_state == S_IDLE) || w_boundary);
    assign w_load_ok  = load && (period_in >= WIDTH'(2));
    assign w_load_bad = load && (period_in <  WIDTH'(2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_boundary)   w_state_nxt = enable ? S_RUN : S_IDLE;
                else if (!enable) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_boundary) w_state_nxt = enable ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next phase so they line up with r_k.
    always_comb begin
        w_per_nxt  = w_apply ? r_sh_per  : r_per;
        w_high_nxt = w_apply ? r_sh_high : r_high;
        w_hlim     = (w_high_nxt >= w_per_nxt) ? (w_per_nxt - WIDTH'(1)) : w_high_nxt;

        if (w_state_nxt == S_IDLE)                w_k_nxt = '0;
        else if (r_state == S_IDLE || w_boundary) w_k_nxt = WIDTH'(1);
        else                                      w_k_nxt = r_k + WIDTH'(1);

        if (w_load_ok)    w_pending_nxt = 1'b1;
        else if (w_apply) w_pending_nxt = 1'b0;
        else              w_pending_nxt = r_pending;

        w_oedge_nxt = (w_k_nxt == WIDTH'(1));
        w_wave_nxt  = (w_k_nxt != '0) && (w_k_nxt <= w_hlim);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k        <= '0;
            r_per      <= WIDTH'(DEF_PERIOD);
            r_high     <= WIDTH'(DEF_HIGH);
            r_sh_per   <= '0;
            r_sh_high  <= '0;
            r_pending  <= 1'b0;
            r_oedge    <= 1'b0;
            r_wave     <= 1'b0;
            r_busy     <= 1'b0;
            r_load_ack <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_k        <= w_k_nxt;
            r_per      <= w_per_nxt;
            r_high     <= w_high_nxt;
            r_pending  <= w_pending_nxt;
            r_oedge    <= w_oedge_nxt;
            r_wave     <= w_wave_nxt;
            r_busy     <= w_busy_nxt;
            r_load_ack <= w_load_ok;
            r_load_err <= w_load_bad;
            if (w_load_ok) begin
                r_sh_per  <= period_in;
                r_sh_high <= high_in;
            end
        end
    end

    assign oedge    = r_oedge;
    assign wave     = r_wave;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign load_ack = r_load_ack;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: timing of oedge/wave, load handling,
// drain behaviour and asynchronous reset, all against hand-derived values.
module tb_edge_pulse_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] period_in;
    logic [7:0] high_in;
    logic       oedge, wave, busy, pending, load_ack, load_err;

    int checks = 0;
    int errors = 0;

    edge_pulse_gen #(.WIDTH(8), .DEF_PERIOD(10), .DEF_HIGH(5)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .period_in(period_in), .high_in(high_in),
        .oedge(oedge), .wave(wave), .busy(busy), .pending(pending),
        .load_ack(load_ack), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 0; load = 0; period_in = 0; high_in = 0;
        reset = 1;
        #7;
        @(negedge clk);
        reset = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1;
        #1;
        checks++;
        if ({oedge, wave, busy, pending, load_ack, load_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000", {oedge, wave, busy, pending, load_ack, load_err});
        end
        reset = 0;
        tick(); tick();
        checks++;
        if ({oedge, wave, busy} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 000", {oedge, wave, busy});
        end
    endtask

    task automatic test_defaults();
        int cnt = 0;
        do_reset();
        enable = 1;
        for (int c = 1; c <= 30; c++) begin
            int k;
            tick();
            k = ((c - 1) % 10) + 1;
            checks++;
            if (oedge !== (k == 1) || wave !== (k <= 5) || busy !== 1'b1) begin
                errors++;
                $display("FAIL defaults c=%0d: got oedge=%b wave=%b busy=%b want %b %b 1", c, oedge, wave, busy, k == 1, k <= 5);
            end
            if (oedge) begin
                if (c > 1) begin
                    checks++;
                    if (cnt != 10) begin
                        errors++;
                        $display("FAIL period_count: got %0d want 10", cnt);
                    end
                end
                cnt = 1;
            end else begin
                cnt++;
            end
        end
    endtask

    task automatic test_load_mid();
        do_reset();
        enable = 1;
        tick(); tick(); tick();                 // k=3
        load = 1; period_in = 4; high_in = 1;
        tick();                                 // k=4
        load = 0;
        checks++;
        if (pending !== 1'b1 || load_ack !== 1'b1) begin
            errors++;
            $display("FAIL load_mid_ack: got pending=%b ack=%b want 1 1", pending, load_ack);
        end
        for (int k = 5; k <= 10; k++) begin
            tick();
            checks++;
            if (oedge !== 1'b0 || wave !== (k <= 5) || pending !== 1'b1 || load_ack !== 1'b0) begin
                errors++;
                $display("FAIL load_mid_old k=%0d: got oedge=%b wave=%b pending=%b ack=%b", k, oedge, wave, pending, load_ack);
            end
        end
        for (int i = 0; i < 12; i++) begin
            int k;
            tick();
            k = (i % 4) + 1;
            checks++;
            if (oedge !== (k == 1) || wave !== (k == 1) || pending !== 1'b0) begin
                errors++;
                $display("FAIL load_mid_new i=%0d: got oedge=%b wave=%b pending=%b want %b %b 0", i, oedge, wave, pending, k == 1, k == 1);
            end
        end
    endtask

    task automatic test_load_err();
        do_reset();
        enable = 1;
        tick();                                 // k=1
        load = 1; period_in = 1; high_in = 3;
        tick();                                 // k=2
        checks++;
        if (load_err !== 1'b1 || load_ack !== 1'b0 || pending !== 1'b0) begin
            errors++;
            $display("FAIL load_err_p1: got err=%b ack=%b pending=%b want 1 0 0", load_err, load_ack, pending);
        end
        period_in = 0;
        tick();                                 // k=3
        load = 0;
        checks++;
        if (load_err !== 1'b1 || pending !== 1'b0) begin
            errors++;
            $display("FAIL load_err_p0: got err=%b pending=%b want 1 0", load_err, pending);
        end
        for (int k = 4; k <= 11; k++) begin
            tick();
            checks++;
            if (load_err !== 1'b0 || oedge !== (k == 11) || wave !== (k <= 5 || k == 11)) begin
                errors++;
                $display("FAIL load_err_timing k=%0d: got err=%b oedge=%b wave=%b", k, load_err, oedge, wave);
            end
        end
    endtask

    task automatic test_clamp_and_zero();
        // P=6 with H=9 clamps to 5 high, then H=0 keeps wave low.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            load = 1; period_in = 6; high_in = (pass == 0) ? 8'd9 : 8'd0;
            tick();
            load = 0;
            checks++;
            if (pending !== 1'b1 || load_ack !== 1'b1) begin
                errors++;
                $display("FAIL idle_capture pass=%0d: got pending=%b ack=%b want 1 1", pass, pending, load_ack);
            end
            tick();
            checks++;
            if (pending !== 1'b0) begin
                errors++;
                $display("FAIL idle_apply pass=%0d: got pending=%b want 0", pass, pending);
            end
            enable = 1;
            for (int i = 0; i < 13; i++) begin
                int k;
                logic exp_wave;
                tick();
                k = (i % 6) + 1;
                exp_wave = (pass == 0) ? (k <= 5) : 1'b0;
                checks++;
                if (oedge !== (k == 1) || wave !== exp_wave) begin
                    errors++;
                    $display("FAIL clamp_zero pass=%0d i=%0d: got oedge=%b wave=%b want %b %b", pass, i, oedge, wave, k == 1, exp_wave);
                end
            end
        end
    endtask

    task automatic test_drain();
        // pass 0: enable stays low; pass 1: enable re-raised at k=8.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            enable = 1;
            tick(); tick(); tick();             // k=3
            enable = 0;
            for (int k = 4; k <= 10; k++) begin
                tick();
                if (k == 8 && pass == 1) enable = 1;
                checks++;
                if (busy !== 1'b1 || oedge !== 1'b0 || wave !== (k <= 5)) begin
                    errors++;
                    $display("FAIL drain pass=%0d k=%0d: got busy=%b oedge=%b wave=%b", pass, k, busy, oedge, wave);
                end
            end
            for (int i = 0; i < 11; i++) begin
                logic exp_oedge;
                logic exp_busy;
                tick();
                exp_oedge = (pass == 1) && (i == 0 || i == 10);
                exp_busy  = (pass == 1);
                checks++;
                if (busy !== exp_busy || oedge !== exp_oedge) begin
                    errors++;
                    $display("FAIL drain_end pass=%0d i=%0d: got busy=%b oedge=%b want %b %b", pass, i, busy, oedge, exp_busy, exp_oedge);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // load with enable rising: first period keeps P=10
        load = 1; enable = 1; period_in = 4; high_in = 1;
        tick();                                 // k=1
        load = 0;
        checks++;
        if (oedge !== 1'b1 || wave !== 1'b1 || pending !== 1'b1 || load_ack !== 1'b1) begin
            errors++;
            $display("FAIL simul_start: got oedge=%b wave=%b pending=%b ack=%b want 1111", oedge, wave, pending, load_ack);
        end
        for (int k = 2; k <= 10; k++) begin
            tick();
            checks++;
            if (oedge !== 1'b0 || wave !== (k <= 5) || pending !== 1'b1) begin
                errors++;
                $display("FAIL simul_old k=%0d: got oedge=%b wave=%b pending=%b", k, oedge, wave, pending);
            end
        end
        tick(); tick(); tick(); tick();         // k=1..4 with P=4
        checks++;
        if (pending !== 1'b0 || oedge !== 1'b0 || wave !== 1'b0) begin
            errors++;
            $display("FAIL simul_p4_k4: got pending=%b oedge=%b wave=%b want 0 0 0", pending, oedge, wave);
        end
        // load on the boundary cycle: the boundary keeps P=4
        load = 1; period_in = 6; high_in = 3;
        tick();                                 // k=1, still P=4
        load = 0;
        checks++;
        if (oedge !== 1'b1 || pending !== 1'b1 || load_ack !== 1'b1) begin
            errors++;
            $display("FAIL boundary_load: got oedge=%b pending=%b ack=%b want 1 1 1", oedge, pending, load_ack);
        end
        // overwrite while pending: last load wins
        load = 1; period_in = 3; high_in = 1;
        tick();                                 // k=2
        load = 0;
        for (int i = 3; i <= 4; i++) begin
            tick();
            checks++;
            if (oedge !== 1'b0 || pending !== 1'b1) begin
                errors++;
                $display("FAIL overwrite_wait k=%0d: got oedge=%b pending=%b want 0 1", i, oedge, pending);
            end
        end
        for (int i = 0; i < 7; i++) begin
            int k;
            tick();
            k = (i % 3) + 1;
            checks++;
            if (oedge !== (k == 1) || wave !== (k == 1) || pending !== 1'b0) begin
                errors++;
                $display("FAIL overwrite_p3 i=%0d: got oedge=%b wave=%b pending=%b want %b %b 0", i, oedge, wave, pending, k == 1, k == 1);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1;
        tick();                                 // k=1
        load = 1; period_in = 4; high_in = 2;
        tick();                                 // k=2, pending
        load = 0;
        checks++;
        if (pending !== 1'b1 || busy !== 1'b1 || wave !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got pending=%b busy=%b wave=%b want 1 1 1", pending, busy, wave);
        end
        #2;
        reset = 1; enable = 0;
        #1;
        checks++;
        if ({oedge, wave, busy, pending, load_ack, load_err} !== 6'b0) begin
            errors++;
            $display("FAIL async_clear: got %b want 000000", {oedge, wave, busy, pending, load_ack, load_err});
        end
        @(negedge clk);
        reset = 0;
        tick();
        enable = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            checks++;
            if (oedge !== (i == 0 || i == 10) || wave !== (i < 5 || i == 10) || pending !== 1'b0) begin
                errors++;
                $display("FAIL async_after i=%0d: got oedge=%b wave=%b pending=%b", i, oedge, wave, pending);
            end
        end
    endtask

    initial begin
        reset = 1; enable = 0; load = 0; period_in = 0; high_in = 0;
        test_reset();
        test_defaults();
        test_load_mid();
        test_load_err();
        test_clamp_and_zero();
        test_drain();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Programmable edge/square-wave generator; the transmit side of the period-measurement path.
- Emits a one-clock edge strobe every P clocks, plus a square wave with programmable high time.
- A downstream period counter that restarts at 1 on each edge reports exactly P.
- Sits between the control/register logic that supplies P and the pins or loopback feeding the frequency meter.

Parameters:
WIDTH, 8, width of period/high-time values and internal phase counter
DEF_PERIOD, 10, active period loaded at reset (must be >= 2)
DEF_HIGH, 5, active high time loaded at reset

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears/initialises all registers immediately
enable  in  1  level; 1 = generate, 0 = finish current period then stop
load  in  1  one-cycle strobe; capture period_in/high_in
period_in  in  WIDTH  requested period P in clocks
high_in  in  WIDTH  requested high time H in clocks
oedge  out  1  one-clock strobe at phase 1 of every period
wave  out  1  square wave
busy  out  1  1 in RUN or DRAIN
pending  out  1  a loaded setting is waiting for the next period boundary
load_ack  out  1  one-cycle pulse, the cycle after an accepted load
load_err  out  1  one-cycle pulse, the cycle after a rejected load (period_in < 2)

Behaviour:
- All outputs are registered.
- Reset values:
  - oedge=0, wave=0, busy=0, pending=0, load_ack=0, load_err=0.
  - State IDLE, phase k=0.
  - Active P=DEF_PERIOD, H=DEF_HIGH; shadow regs = 0.
- Phase counter k runs 1..P in RUN/DRAIN. At k==P, next k=1 (boundary); otherwise k+1. k never exceeds P and never wraps through 0.
- Outputs per phase:
  - oedge=1 exactly when k==1.
  - wave=1 when 1 <= k <= min(H, P-1); otherwise 0. H=0 gives constant 0. H >= P is clamped to P-1, so wave always has at least one low cycle.
- Outputs in IDLE: oedge=0, wave=0, k=0.
- State machine:
  - IDLE: enable=1 -> RUN. The first RUN cycle has k=1 and oedge=1, one clock after enable is sampled high.
  - RUN: enable=0 -> DRAIN (k keeps counting, no truncation). Otherwise stay.
  - DRAIN: at k==P with enable=0 -> IDLE; no further oedge. At k==P with enable=1 -> RUN, k=1, oedge=1 (seamless). enable toggling mid-period in DRAIN has no effect except its value at k==P.
- Edge spacing: consecutive oedge pulses are exactly P clocks apart.
- Load handling:
  - load with period_in >= 2: capture into shadow, pending=1, load_ack pulses next cycle.
  - load with period_in < 2: shadow and pending unchanged, load_err pulses next cycle.
  - load while pending=1: overwrites the shadow (last load wins), pending stays 1.
- Applying a pending setting:
  - In IDLE: pending is applied on the cycle after capture (active P/H updated, pending=0).
  - In RUN/DRAIN: applied only at a boundary (k==P -> 1). The new period starts with the new P/H, so no period ever mixes old and new values.
- Simultaneous events:
  - load in the same cycle as a boundary: captured to shadow, applied at the following boundary. The boundary uses only the shadow that was pending before that cycle.
  - load and enable rising together in IDLE: the first period uses the old active values; the new values apply at the first boundary.
- Reset mid-operation: the asynchronous clear takes effect immediately. After release, state is IDLE with default P/H and the pending load is discarded.

Test Plan:
- Reset then enable=1 held, defaults: oedge at cycles 1, 11, 21; wave high for 5 clocks, low for 5; a period counter restarting at 1 on oedge reads 10.
- load period_in=4, high_in=1 mid-period while running with P=10: pending=1; the current period completes all 10 clocks; then oedge every 4 clocks with wave pattern 1,0,0,0; pending clears at the boundary.
- load period_in=1 and load period_in=0: load_err pulses one cycle each; pending and output timing unchanged.
- P=6, H=9: wave high for 5 cycles, low for 1. H=0: wave stays 0 while oedge still pulses every 6.
- enable dropped at k=3 of P=10: 7 more clocks run, busy falls after k=10, no further oedge. Repeat with enable re-raised at k=8: next oedge at the boundary, spacing still 10.
- Assert reset asynchronously mid-period with pending=1: all outputs 0 immediately, without waiting for a clock edge. After release and enable, period=10 (the shadow was discarded).
